// File: rtl/pipelined_carry_select_addsub.sv
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// Each stage evaluates BLOCKS_PER_STAGE carry-select blocks and hands the
// partial sum, the remaining operand bits and its block carry to the next stage.
module pipelined_carry_select_addsub #(
  parameter int DATA_WIDTH       = 16,
  parameter int BLOCK_SIZE       = 4,
  parameter int BLOCKS_PER_STAGE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Cin,
  input  logic                  SUB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  CF,
  output logic                  OF,
  output logic                  ZF
);
  localparam int NB  = DATA_WIDTH / BLOCK_SIZE;
  localparam int BPS = (BLOCKS_PER_STAGE < 1) ? 1 : BLOCKS_PER_STAGE;
  localparam int LAT = (NB + BPS - 1) / BPS;

  if ((DATA_WIDTH % BLOCK_SIZE) != 0 || BLOCKS_PER_STAGE < 1) begin : g_cfg_err
    $error("pipelined_carry_select_addsub: bad DATA_WIDTH/BLOCK_SIZE/BLOCKS_PER_STAGE");
  end

  // Stage registers. Operand registers keep the full width; the lower,
  // already-consumed slices are never read and trim away in synthesis.
  logic [LAT-1:0]        r_vld_pipe;
  logic [DATA_WIDTH-1:0] r_a [LAT];
  logic [DATA_WIDTH-1:0] r_b [LAT];
  logic [DATA_WIDTH-1:0] r_s [LAT];
  logic [LAT-1:0]        r_c;
  logic                  r_of;
  logic                  r_zf;

  logic [LAT-1:0]        w_rdy;
  logic [LAT-1:0]        w_up_vld;
  logic [DATA_WIDTH-1:0] w_a_src [LAT];
  logic [DATA_WIDTH-1:0] w_b_src [LAT];
  logic [DATA_WIDTH-1:0] w_s_src [LAT];
  logic [DATA_WIDTH-1:0] w_s_nxt [LAT];
  logic [LAT-1:0]        w_c_src;
  logic [LAT-1:0]        w_c_nxt;
  logic [BLOCK_SIZE:0]   w_sum0, w_sum1, w_blk;
  logic                  w_c_msb;

  // Stage inputs: stage 0 sees the (conditionally inverted) operands, later
  // stages see the previous stage's registers.
  always_comb begin
    w_up_vld[0] = in_valid;
    w_a_src[0]  = A;
    w_b_src[0]  = SUB ? ~B : B;
    w_s_src[0]  = '0;
    w_c_src[0]  = SUB ^ Cin;
    for (int s = 1; s < LAT; s++) begin
      w_up_vld[s] = r_vld_pipe[s-1];
      w_a_src[s]  = r_a[s-1];
      w_b_src[s]  = r_b[s-1];
      w_s_src[s]  = r_s[s-1];
      w_c_src[s]  = r_c[s-1];
    end
  end

  // Block evaluation: block 0 ripples from C0, every other block computes both
  // carry hypotheses and selects with the incoming block carry.
  always_comb begin
    w_sum0 = '0;
    w_sum1 = '0;
    w_blk  = '0;
    for (int s = 0; s < LAT; s++) begin
      w_s_nxt[s] = w_s_src[s];
      w_c_nxt[s] = w_c_src[s];
    end
    for (int k = 0; k < NB; k++) begin
      w_sum0 = {1'b0, w_a_src[k/BPS][k*BLOCK_SIZE +: BLOCK_SIZE]}
             + {1'b0, w_b_src[k/BPS][k*BLOCK_SIZE +: BLOCK_SIZE]};
      w_sum1 = {1'b0, w_a_src[k/BPS][k*BLOCK_SIZE +: BLOCK_SIZE]}
             + {1'b0, w_b_src[k/BPS][k*BLOCK_SIZE +: BLOCK_SIZE]}
             + {{BLOCK_SIZE{1'b0}}, 1'b1};
      if (k == 0) w_blk = w_sum0 + {{BLOCK_SIZE{1'b0}}, w_c_nxt[0]};
      else        w_blk = w_c_nxt[k/BPS] ? w_sum1 : w_sum0;
      w_s_nxt[k/BPS][k*BLOCK_SIZE +: BLOCK_SIZE] = w_blk[BLOCK_SIZE-1:0];
      w_c_nxt[k/BPS] = w_blk[BLOCK_SIZE];
    end
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
    w_c_msb = w_a_src[LAT-1][DATA_WIDTH-1] ^ w_b_src[LAT-1][DATA_WIDTH-1]
            ^ w_s_nxt[LAT-1][DATA_WIDTH-1];
  end

  // Ready chain unrolled: stage s may load if any stage at or after it is
  // empty, or the sink accepts. Avoids a combinational self-loop on w_rdy.
  always_comb begin
    for (int s = 0; s < LAT; s++) begin
      w_rdy[s] = out_ready;
      for (int j = s; j < LAT; j++)
        if (!r_vld_pipe[j]) w_rdy[s] = 1'b1;
    end
  end

  // Pipeline registers: valid follows upstream on ready, data only on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_c        <= '0;
      r_of       <= 1'b0;
      r_zf       <= 1'b0;
      for (int s = 0; s < LAT; s++) begin
        r_a[s] <= '0;
        r_b[s] <= '0;
        r_s[s] <= '0;
      end
    end else begin
      for (int s = 0; s < LAT; s++) begin
        if (w_rdy[s]) begin
          r_vld_pipe[s] <= w_up_vld[s];
          if (w_up_vld[s]) begin
            r_a[s] <= w_a_src[s];
            r_b[s] <= w_b_src[s];
            r_s[s] <= w_s_nxt[s];
            r_c[s] <= w_c_nxt[s];
          end
        end
      end
      if (w_rdy[LAT-1] && w_up_vld[LAT-1]) begin
        r_of <= w_c_msb ^ w_c_nxt[LAT-1];
        r_zf <= ~|w_s_nxt[LAT-1];
      end
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_vld_pipe[LAT-1];
  assign S         = r_s[LAT-1];
  assign CF        = r_c[LAT-1];
  assign OF        = r_of;
  assign ZF        = r_zf;
endmodule

// File: tb/tb_pipelined_carry_select_addsub.sv
// Scoreboard bench: drivers push expected results on each accepted transfer,
// per-DUT monitors pop and compare whenever a result is consumed.
module tb_pipelined_carry_select_addsub;
  typedef struct packed { logic [31:0] s; logic cf; logic of; logic zf; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Default configuration (16,4,1): LATENCY 4
  logic        rst0_n, iv0, ir0, cin0, sub0, ov0, or0, cf0, of0, zf0;
  logic [15:0] a0, b0, s0;
  // (32,8,2): LATENCY 2 ; (16,4,4): LATENCY 1
  logic        rst_sw_n;
  logic        iv1, ir1, cin1, sub1, ov1, or1, cf1, of1, zf1;
  logic [31:0] a1, b1, s1;
  logic        iv2, ir2, cin2, sub2, ov2, or2, cf2, of2, zf2;
  logic [15:0] a2, b2, s2;

  exp_t q0[$], q1[$], q2[$];

  pipelined_carry_select_addsub #(.DATA_WIDTH(16), .BLOCK_SIZE(4), .BLOCKS_PER_STAGE(1)) u0 (
    .clk(clk), .rst_n(rst0_n), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0), .Cin(cin0),
    .SUB(sub0), .out_valid(ov0), .out_ready(or0), .S(s0), .CF(cf0), .OF(of0), .ZF(zf0));
  pipelined_carry_select_addsub #(.DATA_WIDTH(32), .BLOCK_SIZE(8), .BLOCKS_PER_STAGE(2)) u1 (
    .clk(clk), .rst_n(rst_sw_n), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1), .Cin(cin1),
    .SUB(sub1), .out_valid(ov1), .out_ready(or1), .S(s1), .CF(cf1), .OF(of1), .ZF(zf1));
  pipelined_carry_select_addsub #(.DATA_WIDTH(16), .BLOCK_SIZE(4), .BLOCKS_PER_STAGE(4)) u2 (
    .clk(clk), .rst_n(rst_sw_n), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2), .Cin(cin2),
    .SUB(sub2), .out_valid(ov2), .out_ready(or2), .S(s2), .CF(cf2), .OF(of2), .ZF(zf2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: {CF,S} = A + B' + C0 over w+1 bits; OF = carry into MSB ^ carry out.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic sb);
    logic [63:0] m, bp, full, low;
    exp_t r;
    m    = (64'd1 << w) - 64'd1;
    bp   = sb ? (~b & m) : (b & m);
    full = (a & m) + bp + {63'd0, sb ^ ci};
    low  = (a & (m >> 1)) + (bp & (m >> 1)) + {63'd0, sb ^ ci};
    r.s  = 32'(full & m);
    r.cf = full[w];
    r.of = low[w-1] ^ full[w];
    r.zf = ((full & m) == 64'd0);
    return r;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that captured it.
  task automatic send0(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                       input logic [15:0] es, input logic ecf, input logic eof, input logic ezf);
    int t;
    a0 = a; b0 = b; cin0 = ci; sub0 = sb; iv0 = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ir0 && t < 50) begin @(negedge clk); t++; end
    if (!ir0) begin
      chk("u0_in_ready_timeout", 64'(ir0), 64'd1);
      iv0 = 1'b0;
    end else begin
      q0.push_back({32'(es), ecf, eof, ezf});
      @(posedge clk); #1;
      iv0 = 1'b0;
    end
  endtask

  // Counts rising edges from the capture edge (inclusive) until out_valid.
  task automatic lat0(output int t);
    t = 1;
    while (!ov0 && t < 20) begin @(posedge clk); #1; t++; end
  endtask

  // u0 monitor: result compare plus hold-while-stalled check.
  exp_t act0, pd0;
  logic pv0 = 1'b0;
  initial forever begin
    @(negedge clk);
    act0 = {32'(s0), cf0, of0, zf0};
    if (rst0_n && pv0) begin
      chk("u0_stall_valid", 64'(ov0), 64'd1);
      chk("u0_stall_data", 64'(act0), 64'(pd0));
    end
    pv0 = rst0_n && ov0 && !or0;
    pd0 = act0;
    if (rst0_n && ov0 && or0) begin
      if (q0.size() == 0) chk("u0_unexpected_out", 64'(ov0), 64'd0);
      else chk("u0_result", 64'(act0), 64'(q0.pop_front()));
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_sw_n && ov1 && or1) begin
      if (q1.size() == 0) chk("u1_unexpected_out", 64'(ov1), 64'd0);
      else chk("u1_result", 64'({s1, cf1, of1, zf1}), 64'(q1.pop_front()));
    end
    if (rst_sw_n && ov2 && or2) begin
      if (q2.size() == 0) chk("u2_unexpected_out", 64'(ov2), 64'd0);
      else chk("u2_result", 64'({16'd0, s2, cf2, of2, zf2}), 64'(q2.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst0_n = 1'b1; rst_sw_n = 1'b1;
    iv0 = 0; a0 = 0; b0 = 0; cin0 = 0; sub0 = 0; or0 = 1;
    iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; or1 = 1;
    iv2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0; or2 = 1;
    #1 rst0_n = 1'b0; rst_sw_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_outputs", 64'({s0, cf0, of0, zf0}), 64'd0);
    chk("rst_in_ready", 64'(ir0), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst0_n = 1'b1; rst_sw_n = 1'b1;

    fork
      begin : seq0
        // directed arithmetic
        send0(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        lat0(t);
        chk("u0_latency", 64'(t), 64'd4);
        send0(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        send0(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        send0(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        send0(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0);
        send0(16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0);
        t = 0;
        while (q0.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
        chk("u0_directed_drained", 64'(q0.size()), 64'd0);

        // backpressure: fill with out_ready low, then release
        or0 = 1'b0;
        send0(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        send0(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
        send0(16'h0010, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        send0(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("u0_in_ready_full", 64'(ir0), 64'd0);
        fork
          begin
            send0(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
            send0(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
          end
          begin
            repeat (2) @(posedge clk);
            #1 or0 = 1'b1;
            for (int i = 0; i < 6; i++) begin
              @(negedge clk);
              chk("u0_no_gap", 64'(ov0), 64'd1);
            end
          end
        join
        t = 0;
        while (q0.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
        chk("u0_bp_drained", 64'(q0.size()), 64'd0);

        // reset with three transactions in flight
        send0(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
        send0(16'h4444, 16'h1111, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        send0(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0);
        rst0_n = 1'b0;
        q0.delete();
        #1;
        chk("u0_rst_mid_valid", 64'(ov0), 64'd0);
        chk("u0_rst_mid_outputs", 64'({s0, cf0, of0, zf0}), 64'd0);
        @(posedge clk); #1 rst0_n = 1'b1;
        chk("u0_rst_mid_in_ready", 64'(ir0), 64'd1);
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("u0_no_stale", 64'(ov0), 64'd0);
        end
        @(posedge clk); #1;
        send0(16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        lat0(t);
        chk("u0_latency_after_rst", 64'(t), 64'd4);
      end

      begin : drv1
        int t1;
        @(posedge clk); #1;
        a1 = 32'hFFFF_FFFF; b1 = 32'h1; cin1 = 0; sub1 = 0; iv1 = 1; or1 = 1;
        @(negedge clk);
        q1.push_back({32'h0, 1'b1, 1'b0, 1'b1});
        @(posedge clk); #1 iv1 = 0;
        t1 = 1;
        while (!ov1 && t1 < 20) begin @(posedge clk); #1; t1++; end
        chk("u1_latency", 64'(t1), 64'd2);
        for (int i = 0; i < 400; i++) begin
          a1 = $urandom; b1 = $urandom; cin1 = 1'($urandom); sub1 = 1'($urandom);
          iv1 = ($urandom_range(0, 3) != 0); or1 = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (iv1 && ir1) q1.push_back(model(32, 64'(a1), 64'(b1), cin1, sub1));
          @(posedge clk); #1;
        end
        iv1 = 0; or1 = 1;
      end

      begin : drv2
        int t2;
        @(posedge clk); #1;
        a2 = 16'h7FFF; b2 = 16'h0001; cin2 = 0; sub2 = 0; iv2 = 1; or2 = 1;
        @(negedge clk);
        q2.push_back({32'h8000, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1 iv2 = 0;
        t2 = 1;
        while (!ov2 && t2 < 20) begin @(posedge clk); #1; t2++; end
        chk("u2_latency", 64'(t2), 64'd1);
        for (int i = 0; i < 400; i++) begin
          a2 = 16'($urandom); b2 = 16'($urandom); cin2 = 1'($urandom); sub2 = 1'($urandom);
          iv2 = ($urandom_range(0, 3) != 0); or2 = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (iv2 && ir2) q2.push_back(model(16, 64'(a2), 64'(b2), cin2, sub2));
          @(posedge clk); #1;
        end
        iv2 = 0; or2 = 1;
      end
    join

    or0 = 1; or1 = 1; or2 = 1;
    t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 50) begin @(posedge clk); #1; t++; end
    chk("queues_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
